// File: rtl/dff_reg_pkg.sv
// Shared definitions for the dff_reg_arbiter block.
//   state_t  : arbiter FSM states
//   MAX_NREQ : largest supported requester count; index vectors are sized for it
//   IDX_W    : width of a requester index
//   rr_pick  : round-robin winner search starting at ptr, wrapping modulo nreq
package dff_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int MAX_NREQ = 8;
    localparam int IDX_W    = $clog2(MAX_NREQ);

    // Lowest rotation distance from ptr wins, so scan from the far end
    // down and let each hit overwrite the previous one.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] req,
        input logic [IDX_W-1:0]    ptr,
        input int                  nreq
    );
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = ptr;
        idx  = 0;
        for (int k = MAX_NREQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                idx = (int'(ptr) + k) % nreq;
                if (req[idx[IDX_W-1:0]]) begin
                    pick = idx[IDX_W-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dff_reg_arbiter_if.sv
// Requester-side bus of the shared register arbiter.
//   req   : per-requester write request (level)
//   lock  : per-requester hold-grant request
//   wdata : packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt   : one-hot registered grant
//   busy  : arbiter is in GRANT
//   q     : shared register contents
//   q_bar : bitwise inverse of q
// master = requester side, slave = arbiter side.
interface dff_reg_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      q_bar;

    modport master (
        output req, lock, wdata,
        input  gnt, busy, q, q_bar
    );

    modport slave (
        input  req, lock, wdata,
        output gnt, busy, q, q_bar
    );

endinterface

// File: rtl/dff_reg.sv
// WIDTH-bit D register with synchronous active-high reset and load enable.
//   clk   : rising-edge clock
//   reset : synchronous reset, clears q (has priority over load)
//   load  : capture d at the next edge
//   d     : data in
//   q     : stored value
//   q_bar : ~q
module dff_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : requester bus (req/lock/wdata in, gnt/busy/q/q_bar out)
//
// state | meaning
// IDLE  | no grant; pick next winner from ptr when any req is set
// GRANT | gnt one-hot on gidx; write on req[gidx], hold while locked
module dff_reg_arbiter
    import dff_reg_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    dff_reg_arbiter_if.slave       bus
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    state_t           state, state_n;
    logic [NREQ-1:0]  gnt_r, gnt_n;
    logic [IDX_W-1:0] gidx, gidx_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] ptr_inc;
    logic [IDX_W-1:0] win;
    logic [CW-1:0]    cnt, cnt_n;
    logic             load;
    logic [WIDTH-1:0] d_sel;
    logic [MAX_NREQ-1:0] req_ext;
    logic [MAX_NREQ-1:0] lock_ext;

    assign req_ext  = MAX_NREQ'(bus.req);
    assign lock_ext = MAX_NREQ'(bus.lock);
    assign win      = rr_pick(req_ext, ptr, NREQ);
    assign ptr_inc  = (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + IDX_W'(1);

    always_comb begin
        d_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == IDX_W'(i)) begin
                d_sel = bus.wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt_r;
        gidx_n  = gidx;
        ptr_n   = ptr;
        cnt_n   = cnt;
        load    = 1'b0;
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (|bus.req) begin
                    for (int i = 0; i < NREQ; i++) begin
                        gnt_n[i] = (win == IDX_W'(i));
                    end
                    gidx_n  = win;
                    cnt_n   = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (req_ext[gidx]) begin
                    load  = 1'b1;
                    cnt_n = cnt + CW'(1);
                    if (!(lock_ext[gidx] && (int'(cnt) + 1 < LOCK_MAX))) begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        ptr_n   = ptr_inc;
                    end
                end else begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = ptr_inc;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt_r <= '0;
            gidx  <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            gnt_r <= gnt_n;
            gidx  <= gidx_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

    assign bus.gnt  = gnt_r;
    assign bus.busy = (state == GRANT);

    // Reset inside dff_reg overrides load, so a reset during GRANT drops the write.
    dff_reg #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .d     (d_sel),
        .q     (bus.q),
        .q_bar (bus.q_bar)
    );

endmodule

// File: tb/tb_dff_reg_arbiter.sv
module tb_dff_reg_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int LOCK_MAX = 4;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    dff_reg_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    dff_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LOCK_MAX(LOCK_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wdata(input int i, input logic [7:0] v);
        bus.wdata[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.req   = 4'($urandom);
        bus.lock  = 4'($urandom);
        bus.wdata = 32'($urandom);
        tick();
        tick();
        tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.q !== 8'h00) begin fails++; $display("FAIL reset_q: got %h expected 00", bus.q); end
        tests++; if (bus.q_bar !== 8'hFF) begin fails++; $display("FAIL reset_qbar: got %h expected ff", bus.q_bar); end
        reset    = 1'b0;
        bus.req  = '0;
        bus.lock = '0;
        tick();
        tick();
        tests++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin fails++; $display("FAIL idle_after_reset: got gnt=%b busy=%b expected 0000/0", bus.gnt, bus.busy); end
    endtask

    task automatic test_single();
        bus.wdata = 32'hDEAD_BE00;
        set_wdata(0, 8'hA5);
        bus.req = 4'b0001;
        tick();
        tests++; if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin fails++; $display("FAIL single_gnt: got gnt=%b busy=%b expected 0001/1", bus.gnt, bus.busy); end
        tests++; if (bus.q !== 8'h00) begin fails++; $display("FAIL single_q_early: got %h expected 00", bus.q); end
        tick();
        bus.req = 4'b0000;
        tests++; if (bus.q !== 8'hA5 || bus.q_bar !== 8'h5A) begin fails++; $display("FAIL single_q: got q=%h qb=%h expected a5/5a", bus.q, bus.q_bar); end
        tests++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin fails++; $display("FAIL single_release: got gnt=%b busy=%b expected 0000/0", bus.gnt, bus.busy); end
        tests++; if (dut.ptr !== 3'd1) begin fails++; $display("FAIL single_ptr: got %0d expected 1", dut.ptr); end
        tick();
        tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL single_idle: got %b expected 0000", bus.gnt); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        logic [7:0] exp_q;
        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_wdata(i, 8'(8'h10 + i));
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            exp_q   = 8'(8'h10 + (k % 4));
            tick();
            tests++; if (bus.gnt !== exp_gnt || bus.busy !== 1'b1) begin fails++; $display("FAIL rr_gnt[%0d]: got gnt=%b busy=%b expected %b/1", k, bus.gnt, bus.busy, exp_gnt); end
            tick();
            if (k == 4) bus.req = 4'b0000;
            tests++; if (bus.q !== exp_q || bus.gnt !== 4'b0000) begin fails++; $display("FAIL rr_q[%0d]: got q=%h gnt=%b expected %h/0000", k, bus.q, bus.gnt, exp_q); end
        end
    endtask

    task automatic test_lock();
        logic [3:0] exp_gnt;
        pulse_reset();
        set_wdata(0, 8'hC3);
        set_wdata(2, 8'h30);
        bus.req  = 4'b0100;
        bus.lock = 4'b0101;
        tick();
        tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL lock_gnt: got %b expected 0100", bus.gnt); end
        bus.req = 4'b0101;
        for (int k = 0; k < LOCK_MAX; k++) begin
            set_wdata(2, 8'(8'h30 + k));
            exp_gnt = (k < LOCK_MAX - 1) ? 4'b0100 : 4'b0000;
            tick();
            tests++; if (bus.q !== 8'(8'h30 + k) || bus.gnt !== exp_gnt) begin fails++; $display("FAIL lock_write[%0d]: got q=%h gnt=%b expected %h/%b", k, bus.q, bus.gnt, 8'(8'h30 + k), exp_gnt); end
        end
        tests++; if (dut.ptr !== 3'd3) begin fails++; $display("FAIL lock_ptr: got %0d expected 3", dut.ptr); end
        bus.req  = 4'b0001;
        bus.lock = 4'b0000;
        set_wdata(2, 8'hEE);
        tick();
        tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL lock_next_gnt: got %b expected 0001", bus.gnt); end
        tick();
        bus.req = 4'b0000;
        tests++; if (bus.q !== 8'hC3 || bus.gnt !== 4'b0000) begin fails++; $display("FAIL lock_next_q: got q=%h gnt=%b expected c3/0000", bus.q, bus.gnt); end
    endtask

    task automatic test_withdraw();
        set_wdata(1, 8'h77);
        bus.req = 4'b0010;
        tick();
        tests++; if (bus.gnt !== 4'b0010) begin fails++; $display("FAIL wd_gnt: got %b expected 0010", bus.gnt); end
        bus.req = 4'b0000;
        tick();
        tests++; if (bus.q !== 8'hC3) begin fails++; $display("FAIL wd_q: got %h expected c3", bus.q); end
        tests++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin fails++; $display("FAIL wd_idle: got gnt=%b busy=%b expected 0000/0", bus.gnt, bus.busy); end
        tests++; if (dut.ptr !== 3'd2) begin fails++; $display("FAIL wd_ptr: got %0d expected 2", dut.ptr); end
    endtask

    task automatic test_reset_mid();
        set_wdata(2, 8'h5A);
        bus.req  = 4'b0100;
        bus.lock = 4'b0100;
        tick();
        tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL rm_gnt: got %b expected 0100", bus.gnt); end
        tick();
        tests++; if (bus.q !== 8'h5A || bus.gnt !== 4'b0100) begin fails++; $display("FAIL rm_locked: got q=%h gnt=%b expected 5a/0100", bus.q, bus.gnt); end
        set_wdata(2, 8'h66);
        reset = 1'b1;
        tick();
        tests++; if (bus.q !== 8'h00 || bus.q_bar !== 8'hFF) begin fails++; $display("FAIL rm_q: got q=%h qb=%h expected 00/ff", bus.q, bus.q_bar); end
        tests++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || dut.ptr !== 3'd0) begin fails++; $display("FAIL rm_state: got gnt=%b busy=%b ptr=%0d expected 0000/0/0", bus.gnt, bus.busy, dut.ptr); end
        reset    = 1'b0;
        bus.req  = 4'b1111;
        bus.lock = 4'b0000;
        tick();
        tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL rm_restart_gnt: got %b expected 0001", bus.gnt); end
        tick();
        bus.req = 4'b0000;
        tests++; if (bus.q !== 8'hC3) begin fails++; $display("FAIL rm_restart_q: got %h expected c3", bus.q); end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        bus.req   = '0;
        bus.lock  = '0;
        bus.wdata = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_withdraw();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
